// File: rtl/bus_addr_decoder.sv
// Serial bus address decoder: captures the slave-select field of each serial
// transaction, routes the remaining write stream to one of three slaves and muxes its read stream back.
`timescale 1ns/1ps
module bus_addr_decoder #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic mwdata,
   input  logic mmode,
   input  logic mvalid,
   output logic mrdata,
   output logic svalid,
   output logic swdata,
   output logic smode,
   output logic mvalid1,
   output logic mvalid2,
   output logic mvalid3,
   input  logic srdata1,
   input  logic srdata2,
   input  logic srdata3,
   input  logic svalid1,
   input  logic svalid2,
   input  logic svalid3,
   output logic dec_err,
   output logic dec_busy
);

   localparam int NUM_SLAVES  = 3;
   localparam int MADDR_WIDTH = ADDR_WIDTH - SEL_WIDTH;
   localparam int SEL_CW      = $clog2(SEL_WIDTH + 1);
   localparam int ADDR_CW     = $clog2(MADDR_WIDTH + 1);
   localparam int DATA_CW     = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {IDLE, SEL, ADDR, WDATA, RDATA} state_t;

   state_t                  state_reg;
   logic                    mode_reg;
   logic                    inv_reg;
   logic [SEL_WIDTH-1:0]    sel_sr_reg;
   logic [1:0]              sel_reg;
   logic [SEL_CW-1:0]       sel_cnt_reg;
   logic [ADDR_CW-1:0]      addr_cnt_reg;
   logic [DATA_CW-1:0]      data_cnt_reg;
   logic                    swdata_reg;
   logic                    smode_reg;
   logic                    dec_err_reg;
   logic [NUM_SLAVES-1:0]   mvalid_reg;

   logic [SEL_WIDTH:0]      sel_ext;
   logic [SEL_WIDTH-1:0]    sel_next;
   logic                    sel_ok;
   logic [NUM_SLAVES-1:0]   sel_onehot;
   logic [NUM_SLAVES-1:0]   srdata_vec;
   logic [NUM_SLAVES-1:0]   svalid_vec;
   logic                    fwd_bit;
   logic                    in_rdata;

   assign sel_ext    = {sel_sr_reg, mwdata};
   assign sel_next   = sel_ext[SEL_WIDTH-1:0];
   assign sel_ok     = (sel_next < SEL_WIDTH'(NUM_SLAVES));
   assign srdata_vec = {srdata3, srdata2, srdata1};
   assign svalid_vec = {svalid3, svalid2, svalid1};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
         assign sel_onehot[gi] = (sel_reg == 2'(gi));
      end
   endgenerate

   // Only address and write-data bits are forwarded; select bits stay local.
   assign fwd_bit  = mvalid && ((state_reg == ADDR) || (state_reg == WDATA));
   assign in_rdata = (state_reg == RDATA);
   assign mrdata   = in_rdata && |(srdata_vec & sel_onehot);
   assign svalid   = in_rdata && |(svalid_vec & sel_onehot);

   assign swdata   = swdata_reg;
   assign smode    = smode_reg;
   assign mvalid1  = mvalid_reg[0];
   assign mvalid2  = mvalid_reg[1];
   assign mvalid3  = mvalid_reg[2];
   assign dec_err  = dec_err_reg;
   assign dec_busy = (state_reg != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         mode_reg     <= 1'b0;
         inv_reg      <= 1'b0;
         sel_sr_reg   <= '0;
         sel_reg      <= '0;
         sel_cnt_reg  <= '0;
         addr_cnt_reg <= '0;
         data_cnt_reg <= '0;
         swdata_reg   <= 1'b0;
         smode_reg    <= 1'b0;
         dec_err_reg  <= 1'b0;
         mvalid_reg   <= '0;
      end else begin
         swdata_reg  <= fwd_bit & mwdata;
         smode_reg   <= fwd_bit & mode_reg;
         mvalid_reg  <= (fwd_bit && !inv_reg) ? sel_onehot : '0;
         dec_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (mvalid) begin
                  mode_reg    <= mmode;
                  sel_sr_reg  <= sel_next;
                  sel_cnt_reg <= SEL_CW'(1);
                  state_reg   <= SEL;
               end
            end
            SEL: begin
               if (mvalid) begin
                  sel_sr_reg  <= sel_next;
                  sel_cnt_reg <= sel_cnt_reg + 1'b1;
                  if (sel_cnt_reg == SEL_CW'(SEL_WIDTH - 1)) begin
                     inv_reg      <= !sel_ok;
                     sel_reg      <= 2'(sel_next);
                     addr_cnt_reg <= '0;
                     state_reg    <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (mvalid) begin
                  addr_cnt_reg <= addr_cnt_reg + 1'b1;
                  if (addr_cnt_reg == ADDR_CW'(MADDR_WIDTH - 1)) begin
                     data_cnt_reg <= '0;
                     if (mode_reg) begin
                        state_reg <= WDATA;
                     end else if (inv_reg) begin
                        dec_err_reg <= 1'b1;
                        state_reg   <= IDLE;
                     end else begin
                        state_reg <= RDATA;
                     end
                  end
               end
            end
            WDATA: begin
               if (mvalid) begin
                  data_cnt_reg <= data_cnt_reg + 1'b1;
                  if (data_cnt_reg == DATA_CW'(DATA_WIDTH - 1)) begin
                     dec_err_reg <= inv_reg;
                     state_reg   <= IDLE;
                  end
               end
            end
            RDATA: begin
               // Only the selected slave's valid advances the read count.
               if (svalid) begin
                  data_cnt_reg <= data_cnt_reg + 1'b1;
                  if (data_cnt_reg == DATA_CW'(DATA_WIDTH - 1))
                     state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Randomized bench for bus_addr_decoder: expected forwarded bits, read bits and
// error pulses are stamped with their cycle and matched by a per-cycle monitor.
`timescale 1ns/1ps
module tb_bus_addr_decoder;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int SW = 4;
   localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       mwdata = 1'b0, mmode = 1'b0, mvalid = 1'b0;
   logic       mrdata, svalid, swdata, smode, mvalid1, mvalid2, mvalid3, dec_err, dec_busy;
   logic [2:0] sr = '0, sv = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [63:0] exp_fwd_q[$];
   logic [63:0] exp_err_q[$];
   logic [63:0] exp_rd_q[$];

   bus_addr_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
      .clk(clk), .rstn(rstn),
      .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
      .mrdata(mrdata), .svalid(svalid),
      .swdata(swdata), .smode(smode),
      .mvalid1(mvalid1), .mvalid2(mvalid2), .mvalid3(mvalid3),
      .srdata1(sr[0]), .srdata2(sr[1]), .srdata3(sr[2]),
      .svalid1(sv[0]), .svalid2(sv[1]), .svalid3(sv[2]),
      .dec_err(dec_err), .dec_busy(dec_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: every observed event, and every cycle an event is due, costs one comparison.
   always @(negedge clk) begin
      if (rstn) begin
         logic [2:0]  m;
         logic [1:0]  idx;
         logic [63:0] e;
         m = {mvalid3, mvalid2, mvalid1};
         case (m)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd3;
         endcase
         if (m != 3'b000 || (exp_fwd_q.size() > 0 && exp_fwd_q[0][35:4] == 32'(cyc))) begin
            e = (exp_fwd_q.size() > 0 && exp_fwd_q[0][35:4] == 32'(cyc)) ? exp_fwd_q.pop_front() : NONE;
            check_val("fwd", {28'd0, 32'(cyc), idx, smode, swdata}, e);
         end
         if (dec_err || (exp_err_q.size() > 0 && exp_err_q[0][31:0] == 32'(cyc))) begin
            e = (exp_err_q.size() > 0 && exp_err_q[0][31:0] == 32'(cyc)) ? exp_err_q.pop_front() : NONE;
            check_val("dec_err", dec_err ? {32'd0, 32'(cyc)} : 64'd0, e);
         end
         if (svalid || (exp_rd_q.size() > 0 && exp_rd_q[0][32:1] == 32'(cyc))) begin
            e = (exp_rd_q.size() > 0 && exp_rd_q[0][32:1] == 32'(cyc)) ? exp_rd_q.pop_front() : NONE;
            check_val("rdata", svalid ? {31'd0, 32'(cyc), mrdata} : 64'd0, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      mvalid = 1'b0;
      mwdata = 1'($urandom);
      mmode  = 1'($urandom);
      sv     = 3'($urandom);
      sr     = 3'($urandom);
      tick();
   endtask

   task automatic send_bit(input logic b, input logic md, input bit fwd, input int slv, input logic exp_md);
      mvalid = 1'b1;
      mwdata = b;
      mmode  = md;
      sv     = 3'($urandom);
      sr     = 3'($urandom);
      if (fwd) exp_fwd_q.push_back({28'd0, 32'(cyc + 1), 2'(slv), exp_md, b});
      tick();
      mvalid = 1'b0;
   endtask

   // gap_mode: 0 continuous, 1 one idle cycle between bits, 2 random 0..2 idle cycles.
   task automatic run_txn(input logic [15:0] addr, input logic md, input logic [7:0] wd,
                          input int gap_mode, input logic [7:0] rd, input bit b2b);
      int  id;
      int  nbits;
      bit  ok;
      logic b;
      id    = int'(addr[15:12]);
      ok    = (id < 3);
      nbits = AW + (md ? DW : 0);
      check_val("busy_idle", dec_busy, 1'b0);
      for (int i = 0; i < nbits; i++) begin
         b = (i < AW) ? addr[AW-1-i] : wd[DW-1-(i-AW)];
         if (i == nbits - 1 && !ok) exp_err_q.push_back({32'd0, 32'(cyc + 1)});
         send_bit(b, (i == 0) ? md : 1'($urandom), ok && i >= SW, id, md);
         if (i == 0) check_val("busy_rise", dec_busy, 1'b1);
         if (i != nbits - 1) begin
            if (gap_mode == 1) idle_cycle();
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
         end
      end
      if (!md && ok) begin
         for (int j = 0; j < DW; j++) begin
            repeat ($urandom_range(0, 2)) begin
               mvalid = 1'($urandom);
               mwdata = 1'($urandom);
               sv = 3'($urandom);
               sr = 3'($urandom);
               sv[id] = 1'b0;
               tick();
            end
            mvalid = 1'($urandom);
            mwdata = 1'($urandom);
            sv = 3'($urandom);
            sr = 3'($urandom);
            sv[id] = 1'b1;
            sr[id] = rd[DW-1-j];
            exp_rd_q.push_back({31'd0, 32'(cyc), rd[DW-1-j]});
            tick();
         end
         mvalid = 1'b0;
         sv = '0;
      end
      check_val("busy_end", dec_busy, 1'b0);
      $display("txn addr=0x%04h mode=%0d wdata=0x%02h rdata=0x%02h gap=%0d b2b=%0d", addr, md, wd, rd, gap_mode, b2b);
      if (!b2b) repeat ($urandom_range(1, 2)) idle_cycle();
   endtask

   task automatic reset_mid_write();
      logic [15:0] addr;
      logic [7:0]  wd;
      logic        b;
      addr = {4'h1, 12'($urandom)};
      wd   = 8'($urandom);
      for (int i = 0; i < AW + 3; i++) begin
         b = (i < AW) ? addr[AW-1-i] : wd[DW-1-(i-AW)];
         send_bit(b, (i == 0) ? 1'b1 : 1'($urandom), i >= SW, 1, 1'b1);
      end
      check_val("pre_rst_mvalid2", mvalid2, 1'b1);
      rstn = 1'b0;
      #1;
      check_val("rst_async", {swdata, smode, mvalid3, mvalid2, mvalid1, mrdata, svalid, dec_err, dec_busy}, 9'd0);
      exp_fwd_q.delete();
      exp_err_q.delete();
      exp_rd_q.delete();
      $display("txn reset during write data bit 3, addr=0x%04h", addr);
      tick();
      tick();
      rstn = 1'b1;
      idle_cycle();
      run_txn({4'h0, 12'($urandom)}, 1'b1, 8'($urandom), 0, 8'h00, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] id;
      #3;
      check_val("reset", {swdata, smode, mvalid3, mvalid2, mvalid1, mrdata, svalid, dec_err, dec_busy}, 9'd0);
      tick();
      tick();
      rstn = 1'b1;
      idle_cycle();

      run_txn(16'h11A5, 1'b1, 8'h3C, 0, 8'h00, 1'b0);
      run_txn(16'h21A5, 1'b0, 8'h00, 0, 8'h96, 1'b0);
      run_txn(16'h5000, 1'b1, 8'hA7, 0, 8'h00, 1'b0);
      run_txn(16'h5000, 1'b0, 8'h00, 0, 8'h00, 1'b0);
      run_txn(16'h01A5, 1'b1, 8'h3C, 1, 8'h00, 1'b0);
      run_txn(16'h2123, 1'b0, 8'h00, 2, 8'h5A, 1'b1);
      run_txn(16'h0FFF, 1'b1, 8'hFF, 0, 8'h00, 1'b1);
      run_txn(16'hF000, 1'b1, 8'h00, 0, 8'h00, 1'b1);
      run_txn(16'h1000, 1'b0, 8'h00, 0, 8'h01, 1'b0);
      reset_mid_write();

      for (int t = 0; t < 60; t++) begin
         id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
         run_txn({id, 12'($urandom)}, 1'($urandom), 8'($urandom), $urandom_range(0, 2),
                 8'($urandom), 1'($urandom));
      end

      repeat (3) idle_cycle();
      check_val("fwd_left", 64'(exp_fwd_q.size()), 64'd0);
      check_val("err_left", 64'(exp_err_q.size()), 64'd0);
      check_val("rd_left", 64'(exp_rd_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
